// File: rtl/adc_sequencer.sv
// ADC channel sequencer: walks the enabled channels of a 32-way analog mux, runs one
// conversion per channel and publishes each result as a strobed sample. Wishbone slave.
module adc_sequencer #(
  parameter int SETTLE_W = 8,
  parameter int MIN_GAP  = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [15:0]         wb_adr_i,
  input  logic [15:0]         wb_dat_i,
  output logic [15:0]         wb_dat_o,
  output logic                wb_ack_o,
  output logic [4:0]          acm_chnum,
  output logic                acm_start,
  input  logic                acm_busy,
  input  logic                acm_datavalid,
  input  logic [11:0]         acm_result,
  output logic                adc_strb,
  output logic [4:0]          adc_channel,
  output logic [11:0]         adc_result
);
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  // GAP is entered one cycle after EMIT, so loading MIN_GAP-2 keeps strobes >= MIN_GAP apart
  localparam logic [GAP_W-1:0] GAP_LOAD = (MIN_GAP > 2) ? GAP_W'(MIN_GAP - 2) : '0;

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_SETTLE, S_WAIT, S_EMIT, S_GAP} state_t;

  state_t              state, state_next;
  logic                enable, timeout_sticky;
  logic [31:0]         mask;
  logic [SETTLE_W-1:0] settle, settle_cnt;
  logic [TO_W-1:0]     wait_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [4:0]          ptr;
  logic [15:0]         sweep_count;
  logic [15:0]         rd_data;
  logic                trans, run_ok, hit, timeout_hit, advance;

  assign trans       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign run_ok      = enable && (mask != 32'd0);
  assign hit         = (state == S_SELECT) && run_ok && mask[ptr];
  assign timeout_hit = (state == S_WAIT) && !acm_datavalid && (wait_cnt == TO_LAST);
  assign advance     = ((state == S_SELECT) && run_ok && !mask[ptr]) ||
                       (state == S_EMIT) || timeout_hit;

  always_comb begin
    state_next = state;
    acm_start  = 1'b0;
    adc_strb   = 1'b0;
    case (state)
      S_IDLE:   if (run_ok) state_next = S_SELECT;
      S_SELECT: begin
        if (!run_ok)       state_next = S_IDLE;
        else if (mask[ptr]) state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if ((settle_cnt == '0) && !acm_busy) begin
          acm_start  = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (acm_datavalid)  state_next = S_EMIT;
        else if (timeout_hit) state_next = S_SELECT;
      end
      S_EMIT: begin
        adc_strb   = 1'b1;
        state_next = S_GAP;
      end
      S_GAP:    if (gap_cnt == '0) state_next = S_SELECT;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= S_IDLE;
      ptr         <= 5'd0;
      sweep_count <= 16'd0;
      settle_cnt  <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      acm_chnum   <= 5'd0;
      adc_channel <= 5'd0;
      adc_result  <= 12'd0;
    end else begin
      state <= state_next;
      if (advance) begin
        ptr <= ptr + 5'd1;
        if (ptr == 5'd31) sweep_count <= sweep_count + 16'd1;
      end
      if (hit) begin
        acm_chnum  <= ptr;
        settle_cnt <= settle;
      end else if ((state == S_SETTLE) && (settle_cnt != '0)) begin
        settle_cnt <= settle_cnt - SETTLE_W'(1);
      end
      wait_cnt <= (state == S_WAIT) ? wait_cnt + TO_W'(1) : '0;
      // Sample registers change on the WAIT->EMIT edge so they are already valid with adc_strb
      if ((state == S_WAIT) && acm_datavalid) begin
        adc_channel <= acm_chnum;
        adc_result  <= acm_result;
      end
      if (state == S_EMIT) gap_cnt <= GAP_LOAD;
      else if ((state == S_GAP) && (gap_cnt != '0)) gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  always_comb begin
    rd_data = 16'd0;
    case (wb_adr_i)
      16'd0:   rd_data = {14'd0, timeout_sticky, enable};
      16'd1:   rd_data = mask[15:0];
      16'd2:   rd_data = mask[31:16];
      16'd3:   rd_data = 16'(settle);
      16'd4:   rd_data = {11'd0, adc_channel};
      16'd5:   rd_data = {4'd0, adc_result};
      16'd6:   rd_data = sweep_count;
      default: rd_data = 16'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o       <= 1'b0;
      wb_dat_o       <= 16'd0;
      enable         <= 1'b0;
      mask           <= 32'd0;
      settle         <= '0;
      timeout_sticky <= 1'b0;
    end else begin
      wb_ack_o <= trans;
      wb_dat_o <= (trans && !wb_we_i) ? rd_data : 16'd0;
      if (timeout_hit) timeout_sticky <= 1'b1;
      if (trans && wb_we_i) begin
        case (wb_adr_i)
          16'd0: begin
            enable         <= wb_dat_i[0];
            timeout_sticky <= 1'b0;
          end
          16'd1:   mask[15:0]  <= wb_dat_i;
          16'd2:   mask[31:16] <= wb_dat_i;
          16'd3:   settle      <= wb_dat_i[SETTLE_W-1:0];
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer with a simple behavioural ADC that answers
// four cycles after each start pulse.
module tb_adc_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [15:0] wb_adr = 16'd0, wb_dat_w = 16'd0;
  logic [15:0] wb_dat_r;
  logic        wb_ack;
  logic [4:0]  acm_chnum;
  logic        acm_start;
  logic        busy = 1'b0;
  logic        dv = 1'b0;
  logic [11:0] res_in = 12'd0;
  logic        adc_strb;
  logic [4:0]  adc_channel;
  logic [11:0] adc_result;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int start_cnt = 0;
  int strb_ch[$];
  int strb_res[$];
  int strb_cyc[$];
  bit          model_on = 1'b1;
  bit          model_fixed = 1'b0;
  logic [11:0] model_val = 12'd0;
  logic [4:0]  mch;

  adc_sequencer dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_dat_o(wb_dat_r), .wb_ack_o(wb_ack),
    .acm_chnum(acm_chnum), .acm_start(acm_start), .acm_busy(busy),
    .acm_datavalid(dv), .acm_result(res_in),
    .adc_strb(adc_strb), .adc_channel(adc_channel), .adc_result(adc_result)
  );

  always #5 clk = ~clk;

  // Monitor: logs every strobe and counts start pulses
  initial begin
    forever begin
      @(negedge clk); #3;
      cycle++;
      if (acm_start) start_cnt++;
      if (adc_strb) begin
        strb_ch.push_back(int'(adc_channel));
        strb_res.push_back(int'(adc_result));
        strb_cyc.push_back(cycle);
      end
    end
  end

  // ADC model: result is chnum*100 (or a fixed value) four cycles after start
  initial begin
    forever begin
      @(negedge clk); #4;
      if (acm_start && model_on) begin
        mch = acm_chnum;
        repeat (4) @(negedge clk);
        dv = 1'b1;
        res_in = model_fixed ? model_val : 12'(int'(mch) * 100);
        @(negedge clk);
        dv = 1'b0;
        res_in = 12'd0;
      end
    end
  end

  task automatic step();
    @(negedge clk); #2;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; busy = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic wb_write(input logic [15:0] a, input logic [15:0] d);
    int n;
    step();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = a; wb_dat_w = d;
    n = 0;
    do begin step(); n++; end while (wb_ack !== 1'b1 && n < 8);
    checks++;
    if (wb_ack !== 1'b1) begin errors++; $display("FAIL wb_write_ack adr=%0d ack=%b want 1", a, wb_ack); end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [15:0] a, output logic [15:0] d);
    int n;
    step();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = a;
    n = 0;
    do begin step(); n++; end while (wb_ack !== 1'b1 && n < 8);
    d = wb_dat_r;
    checks++;
    if (wb_ack !== 1'b1) begin errors++; $display("FAIL wb_read_ack adr=%0d ack=%b want 1", a, wb_ack); end
    wb_cyc = 1'b0; wb_stb = 1'b0;
  endtask

  task automatic wait_start(input int bound, output bit got);
    int n = 0;
    got = 1'b0;
    while (!got && n < bound) begin step(); n++; if (acm_start === 1'b1) got = 1'b1; end
  endtask

  task automatic wait_strb(input int idx, input int bound, output bit got);
    int n = 0;
    while (strb_ch.size() <= idx && n < bound) begin step(); n++; end
    got = (strb_ch.size() > idx);
  endtask

  task automatic test_reset();
    logic [15:0] d;
    do_reset();
    checks++;
    if ({acm_start, acm_chnum, adc_strb, adc_channel, adc_result, wb_ack, wb_dat_r} !== '0) begin
      errors++;
      $display("FAIL reset_outputs start=%b chnum=%0d strb=%b ch=%0d res=%h ack=%b dat=%h want all 0",
               acm_start, acm_chnum, adc_strb, adc_channel, adc_result, wb_ack, wb_dat_r);
    end
    wb_read(16'd0, d); checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL reset_ctrl got %h want 0000", d); end
    wb_read(16'd6, d); checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL reset_sweep got %h want 0000", d); end
    wb_read(16'd5, d); checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL reset_last_result got %h want 0000", d); end
  endtask

  task automatic test_registers();
    logic [15:0] d;
    do_reset();
    wb_write(16'd2, 16'hBEEF); wb_read(16'd2, d); checks++;
    if (d !== 16'hBEEF) begin errors++; $display("FAIL mask_hi_readback got %h want beef", d); end
    wb_write(16'd1, 16'h1234); wb_read(16'd1, d); checks++;
    if (d !== 16'h1234) begin errors++; $display("FAIL mask_lo_readback got %h want 1234", d); end
    wb_write(16'd3, 16'h1234); wb_read(16'd3, d); checks++;
    if (d !== 16'h0034) begin errors++; $display("FAIL settle_width got %h want 0034", d); end
    wb_write(16'd7, 16'hFFFF); wb_read(16'd7, d); checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL unmapped_read got %h want 0000", d); end
    wb_write(16'd5, 16'h0FFF); wb_read(16'd5, d); checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL last_result_ro got %h want 0000", d); end
  endtask

  task automatic test_two_channel();
    logic [15:0] d;
    bit got;
    int base, ch_exp;
    do_reset();
    base = strb_ch.size();
    wb_write(16'd1, 16'h0005);
    wb_write(16'd0, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      wait_strb(base + i, 300, got);
      checks++;
      if (!got) begin errors++; $display("FAIL two_ch_strobe%0d got none want strobe", i); end
      else begin
        ch_exp = (i % 2 == 1) ? 2 : 0;
        checks++;
        if (strb_ch[base+i] != ch_exp || strb_res[base+i] != ch_exp * 100) begin
          errors++;
          $display("FAIL two_ch_sample%0d got ch=%0d res=%0d want ch=%0d res=%0d",
                   i, strb_ch[base+i], strb_res[base+i], ch_exp, ch_exp * 100);
        end
        if (i > 0) begin
          checks++;
          if (strb_cyc[base+i] - strb_cyc[base+i-1] < 16) begin
            errors++;
            $display("FAIL two_ch_spacing%0d got %0d want >=16", i, strb_cyc[base+i] - strb_cyc[base+i-1]);
          end
        end
      end
    end
    wb_read(16'd6, d); checks++;
    if (d !== 16'd1) begin errors++; $display("FAIL sweep_after_two_passes got %0d want 1", d); end
    wb_read(16'd4, d); checks++;
    if (d !== 16'd2) begin errors++; $display("FAIL last_channel got %0d want 2", d); end
    wb_read(16'd5, d); checks++;
    if (d !== 16'd200) begin errors++; $display("FAIL last_result got %0d want 200", d); end
    wait_strb(base + 5, 300, got);
    wb_read(16'd6, d); checks++;
    if (d !== 16'd2) begin errors++; $display("FAIL sweep_after_three_passes got %0d want 2", d); end
  endtask

  task automatic test_settle();
    int n;
    bit bad;
    do_reset();
    wb_write(16'd1, 16'h0080);
    wb_write(16'd3, 16'd10);
    wb_write(16'd0, 16'h0001);
    n = 0;
    while (acm_chnum !== 5'd7 && n < 100) begin step(); n++; end
    checks++;
    if (acm_chnum !== 5'd7) begin errors++; $display("FAIL settle_chnum_select got %0d want 7", acm_chnum); end
    n = 0; bad = 1'b0;
    while (acm_start !== 1'b1 && n < 50) begin
      step(); n++;
      if (acm_chnum !== 5'd7) bad = 1'b1;
    end
    checks++;
    if (n != 10) begin errors++; $display("FAIL settle_delay got %0d cycles after SETTLE entry want 10", n); end
    checks++;
    if (bad) begin errors++; $display("FAIL settle_chnum_hold got changed want 7 throughout"); end
  endtask

  task automatic test_timeout();
    logic [15:0] d;
    bit got;
    int base;
    do_reset();
    model_on = 1'b0;
    base = strb_ch.size();
    wb_write(16'd1, 16'h0002);
    wb_write(16'd0, 16'h0001);
    wait_start(60, got);
    checks++;
    if (!got) begin errors++; $display("FAIL timeout_first_start got none want pulse"); end
    repeat (995) step();
    wb_read(16'd0, d); checks++;
    if (d !== 16'h0001) begin errors++; $display("FAIL ctrl_before_timeout got %h want 0001", d); end
    repeat (40) step();
    wb_read(16'd0, d); checks++;
    if (d !== 16'h0003) begin errors++; $display("FAIL ctrl_after_timeout got %h want 0003", d); end
    checks++;
    if (strb_ch.size() != base) begin errors++; $display("FAIL timeout_no_strobe got %0d want 0", strb_ch.size() - base); end
    wb_write(16'd0, 16'h0001);
    wb_read(16'd0, d); checks++;
    if (d !== 16'h0001) begin errors++; $display("FAIL ctrl_sticky_clear got %h want 0001", d); end
    model_on = 1'b1;
  endtask

  task automatic test_disable_in_wait();
    logic [15:0] d;
    bit got;
    int base, s0;
    do_reset();
    model_fixed = 1'b1; model_val = 12'hABC;
    base = strb_ch.size();
    wb_write(16'd1, 16'h0008);
    wb_write(16'd0, 16'h0001);
    wait_start(60, got);
    wb_write(16'd0, 16'h0000);
    wait_strb(base, 60, got);
    checks++;
    if (!got) begin errors++; $display("FAIL disable_pending_strobe got none want ch3"); end
    else begin
      checks++;
      if (strb_ch[base] != 3 || strb_res[base] != 'hABC) begin
        errors++;
        $display("FAIL disable_sample got ch=%0d res=%h want ch=3 res=abc", strb_ch[base], strb_res[base]);
      end
    end
    s0 = start_cnt;
    repeat (80) step();
    checks++;
    if (start_cnt != s0 || strb_ch.size() != base + 1) begin
      errors++;
      $display("FAIL disable_idle got starts=%0d strobes=%0d want 0 and 0", start_cnt - s0, strb_ch.size() - base - 1);
    end
    wb_read(16'd5, d); checks++;
    if (d !== 16'h0ABC) begin errors++; $display("FAIL disable_last_result got %h want 0abc", d); end
    model_fixed = 1'b0;
  endtask

  task automatic test_busy();
    bit got;
    int base, s0, n;
    do_reset();
    base = strb_ch.size();
    busy = 1'b1;
    wb_write(16'd1, 16'h0020);
    wb_write(16'd0, 16'h0001);
    n = 0;
    while (acm_chnum !== 5'd5 && n < 100) begin step(); n++; end
    s0 = start_cnt;
    repeat (20) step();
    checks++;
    if (start_cnt != s0) begin errors++; $display("FAIL busy_hold got %0d starts want 0", start_cnt - s0); end
    busy = 1'b0;
    repeat (12) step();
    checks++;
    if (start_cnt != s0 + 1) begin errors++; $display("FAIL busy_release got %0d starts want 1", start_cnt - s0); end
    wait_strb(base, 60, got);
    checks++;
    if (!got || strb_ch[base] != 5 || strb_res[base] != 500) begin
      errors++;
      $display("FAIL busy_sample got %0d strobes want ch=5 res=500", strb_ch.size() - base);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [15:0] d;
    bit got;
    int base;
    do_reset();
    model_fixed = 1'b1; model_val = 12'h123;
    wb_write(16'd1, 16'h0008);
    wb_write(16'd0, 16'h0001);
    wait_start(60, got);
    base = strb_ch.size();
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    repeat (30) step();
    checks++;
    if (strb_ch.size() != base) begin errors++; $display("FAIL reset_wait_strobe got %0d want 0", strb_ch.size() - base); end
    checks++;
    if ({acm_start, acm_chnum, adc_strb, adc_channel, adc_result} !== '0) begin
      errors++;
      $display("FAIL reset_wait_outputs chnum=%0d ch=%0d res=%h want all 0", acm_chnum, adc_channel, adc_result);
    end
    wb_read(16'd5, d); checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL reset_wait_last_result got %h want 0000", d); end
    wb_read(16'd0, d); checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL reset_wait_ctrl got %h want 0000", d); end
    model_fixed = 1'b0;
  endtask

  initial begin
    test_reset();
    test_registers();
    test_two_channel();
    test_settle();
    test_timeout();
    test_disable_in_wait();
    test_busy();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_sequencer.md
Name: adc_sequencer

Overview:
- Producer side of the ADC sample stream consumed by the voltage/current level checker.
- Steps through the enabled channels of a 32-channel analog mux and runs one conversion per channel on the analog core.
- Presents each result as a single-cycle adc_strb with adc_channel and adc_result.
- Wishbone slave for channel mask, settling time, status and readback.

Parameters:
- SETTLE_W, 8: width of the settle register and counter.
- MIN_GAP, 16: minimum cycles between successive adc_strb pulses; gives the downstream checker time to finish.
- TIMEOUT, 1024: cycles allowed between acm_start and acm_datavalid.

Ports:
- wb_clk_i  in  1  system clock; single clock domain.
- wb_rst_i  in  1  synchronous, active-high reset.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone control.
- wb_adr_i  in  16  register address.
- wb_dat_i  in  16  write data.
- wb_dat_o  out  16  read data.
- wb_ack_o  out  1  transfer acknowledge.
- acm_chnum  out  5  analog mux channel select.
- acm_start  out  1  conversion start pulse.
- acm_busy  in  1  ADC busy.
- acm_datavalid  in  1  conversion done; acm_result is valid in this cycle.
- acm_result  in  12  conversion result.
- adc_strb  out  1  sample-valid pulse.
- adc_channel  out  5  channel of the current sample.
- adc_result  out  12  value of the current sample.

Behaviour:
- Reset values:
  - All outputs 0.
  - enable=0, mask=0, settle=0, timeout_sticky=0, sweep_count=0, ptr=0, state IDLE.
- Wishbone:
  - trans = cyc&stb&~ack.
  - ack asserts 1 cycle after trans and lasts 1 cycle; no wait states.
  - wb_dat_o is registered at ack.
- Register map (reads of unlisted addresses return 0; writes to them are ignored):
  - 0 CTRL: bit0 enable (RW); bit1 timeout_sticky (RO; any write to CTRL clears it).
  - 1 MASK_LO = mask[15:0].
  - 2 MASK_HI = mask[31:16].
  - 3 SETTLE: [SETTLE_W-1:0] settle cycles.
  - 4 LAST_CHANNEL (RO).
  - 5 LAST_RESULT (RO).
  - 6 SWEEP_COUNT (RO; 16-bit, wraps).
- State machine:
  - IDLE: if enable && mask!=0, go to SELECT.
  - SELECT: scans one channel per cycle.
    - Re-checks enable and mask each cycle; if either fails, go to IDLE.
    - If mask[ptr]=1: acm_chnum<=ptr, load settle counter, go to SETTLE.
    - Otherwise advance ptr.
  - SETTLE: count settle cycles (0 = none).
    - When the count is done and acm_busy=0, pulse acm_start for exactly 1 cycle and go to WAIT.
    - If acm_busy=1, hold.
  - WAIT: on acm_datavalid, capture acm_result and go to EMIT.
    - If TIMEOUT cycles pass with no datavalid: set timeout_sticky, advance ptr, return to SELECT, emit no strobe.
  - EMIT: adc_strb=1 for one cycle.
    - adc_channel/adc_result update in the same cycle and hold until the next EMIT.
    - LAST_CHANNEL/LAST_RESULT update.
    - Advance ptr, then go to GAP.
  - GAP: wait so that consecutive strobes are at least MIN_GAP cycles apart, then go to SELECT.
- ptr advance: 31 wraps to 0, and sweep_count increments on each wrap (SELECT skip, EMIT or timeout).
- Enable cleared mid-conversion: the current conversion completes and emits; the next SELECT then goes to IDLE. acm_start is never aborted.
- Mask write during operation: takes effect at the next SELECT evaluation. A channel already in SETTLE/WAIT finishes.
- wb_rst_i mid-operation: immediate return to reset values; any pending datavalid is ignored.
- Single enabled channel: the same channel repeats, with strobe spacing ≥ MIN_GAP.

Test Plan:
- mask=0x0000_0005, settle=0, enable=1; model returns channel*100 after 4 cycles -> strobes alternate ch0=0, ch2=200; sweep_count increments once per 0→2→0 pass; spacing ≥16 cycles.
- settle=10 on ch7 only -> acm_start occurs exactly 11 cycles after SELECT hits ch7; acm_chnum=7 throughout.
- ADC never asserts datavalid -> after 1024 cycles, CTRL reads 0x0003 and no strobe occurs; writing CTRL=1 -> CTRL reads 0x0001.
- Clear enable while in WAIT -> the pending sample (ch3, 0xABC) is still strobed, then state is IDLE and acm_start stays 0.
- acm_busy held high for 20 cycles in SETTLE -> acm_start delayed until busy falls; exactly one start pulse.
- Assert wb_rst_i mid-WAIT, then datavalid -> no strobe; LAST_RESULT=0; all outputs 0.
